// File: rtl/ysyx_22040759_rf_warb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_22040759_rf_warb_pkg : shared widths, defaults and write-port selects
// Revision : 1.0
// ----------------------------------------------------------------------------
package ysyx_22040759_rf_warb_pkg;

  localparam int c_xlen           = 64;
  localparam int c_reg_aw         = 5;
  localparam int c_depth_def      = 2;
  localparam int c_starve_max_def = 4;

  typedef enum logic [1:0] {
    c_wreg_none = 2'd0,
    c_wreg_wb   = 2'd1,
    c_wreg_mdu  = 2'd2
  } wreg_sel_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040759_rf_wfifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_22040759_rf_wfifo : DEPTH x (addr+data) circular FIFO with per-entry view
// Revision : 1.0
// ----------------------------------------------------------------------------
module ysyx_22040759_rf_wfifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DW-1:0]         i_wdata,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [AW-1:0]         o_head_addr,
  output logic [DW-1:0]         o_head_data,
  output logic [DEPTH-1:0]      o_vld,
  output logic [DEPTH*AW-1:0]   o_addr
);

  localparam int c_pw = $clog2(DEPTH);
  localparam logic [c_pw:0] c_full_cnt = (c_pw+1)'(DEPTH);

  logic [c_pw-1:0]  r_head;
  logic [c_pw-1:0]  r_tail;
  logic [c_pw:0]    r_count;
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == c_full_cnt);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      // push and pop never address the same slot: push needs !full, pop needs !empty
      if (w_push) begin
        r_tail        <= r_tail + c_pw'(1);
        r_vld[r_tail] <= 1'b1;
      end
      if (w_pop) begin
        r_head        <= r_head + c_pw'(1);
        r_vld[r_head] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_pw+1)'(1);
        2'b01:   r_count <= r_count - (c_pw+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= i_waddr;
      r_data[r_tail] <= i_wdata;
    end
  end

  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_vld       = r_vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_addr_flat
    assign o_addr[i*AW +: AW] = r_addr[i];
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040759_rf_warb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_22040759_rf_warb : shares the RF write port between WB and buffered MDU results
// Revision : 1.0
// ----------------------------------------------------------------------------
module ysyx_22040759_rf_warb
  import ysyx_22040759_rf_warb_pkg::*;
#(
  parameter int DEPTH      = c_depth_def,
  parameter int STARVE_MAX = c_starve_max_def,
  parameter int XLEN       = c_xlen
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_wen,
  input  logic [c_reg_aw-1:0] wb_waddr,
  input  logic [XLEN-1:0]     wb_wdata,
  output logic                wb_hold,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [c_reg_aw-1:0] md_waddr,
  input  logic [XLEN-1:0]     md_wdata,
  output logic                rf_wen,
  output logic [c_reg_aw-1:0] rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [31:0]         pend_mask
);

  localparam int c_cw = $clog2(STARVE_MAX) + 1;
  localparam logic [c_cw-1:0] c_starve_sat = c_cw'(STARVE_MAX);

  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic [c_reg_aw-1:0]       w_head_addr;
  logic [XLEN-1:0]           w_head_data;
  logic [DEPTH-1:0]          w_vld;
  logic [DEPTH*c_reg_aw-1:0] w_addr;
  logic [c_cw-1:0]           r_starve;
  wreg_sel_e                 w_sel;

  // x0 results complete the handshake but are never buffered
  assign md_ready = !w_full;
  assign w_push   = md_valid && !w_full && (md_waddr != '0);
  assign wb_hold  = !w_empty && (r_starve == c_starve_sat);

  always_comb begin
    w_sel = c_wreg_none;
    if (wb_wen && !wb_hold) begin
      w_sel = c_wreg_wb;
    end else if (!w_empty) begin
      w_sel = c_wreg_mdu;
    end
  end

  assign w_pop    = (w_sel == c_wreg_mdu);
  assign rf_wen   = (w_sel != c_wreg_none);
  assign rf_waddr = w_pop ? w_head_addr : wb_waddr;
  assign rf_wdata = w_pop ? w_head_data : wb_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_pop || w_empty) begin
      r_starve <= '0;
    end else if (r_starve != c_starve_sat) begin
      r_starve <= r_starve + c_cw'(1);
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_vld[i]) pend_mask[w_addr[i*c_reg_aw +: c_reg_aw]] = 1'b1;
    end
  end

  ysyx_22040759_rf_wfifo #(
    .DEPTH (DEPTH),
    .AW    (c_reg_aw),
    .DW    (XLEN)
  ) u_wfifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_waddr     (md_waddr),
    .i_wdata     (md_wdata),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_vld       (w_vld),
    .o_addr      (w_addr)
  );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040759_rf_warb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ysyx_22040759_rf_warb : scoreboard bench for the RF write-port arbiter
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_ysyx_22040759_rf_warb;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        wb_hold;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_waddr;
  logic [63:0] md_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] pend_mask;

  wr_t sb[$];
  int  checks;
  int  failures;

  ysyx_22040759_rf_warb #(
    .DEPTH      (2),
    .STARVE_MAX (4),
    .XLEN       (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_wen    (wb_wen),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .wb_hold   (wb_hold),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_waddr  (md_waddr),
    .md_wdata  (md_wdata),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (wb_hold !== 1'b0 || md_ready !== 1'b1 || pend_mask !== 32'h0 || rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: hold=%b ready=%b pend=%h wen=%b, want 0 1 0 0",
               wb_hold, md_ready, pend_mask, rf_wen);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_wb_only();
    wr_t e;
    for (int c = 0; c < 3; c++) begin
      wb_wen   = 1'b1;
      wb_waddr = 5'd5 + 5'(c);
      wb_wdata = 64'h1234 + 64'(c) * 64'h1111_0000;
      sb.push_back('{a: wb_waddr, d: wb_wdata});
      @(negedge clk);
      checks++;
      if (wb_hold !== 1'b0) begin
        failures++;
        $display("FAIL wb_only_hold c=%0d: got %b want 0", c, wb_hold);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wb_only_write c=%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if (rf_wen !== 1'b1 || rf_waddr !== e.a || rf_wdata !== e.d) begin
          failures++;
          $display("FAIL wb_only_write c=%0d: got wen=%b a=%0d d=%h want wen=1 a=%0d d=%h",
                   c, rf_wen, rf_waddr, rf_wdata, e.a, e.d);
        end
      end
      next_cycle();
    end
    wb_wen = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL wb_only_idle: got wen=%b want 0", rf_wen);
    end
    next_cycle();
  endtask

  task automatic test_mdu_idle();
    wr_t e;
    md_valid = 1'b1;
    md_waddr = 5'd7;
    md_wdata = 64'hABCD;
    sb.push_back('{a: 5'd7, d: 64'hABCD});
    @(negedge clk);
    checks++;
    if (md_ready !== 1'b1 || rf_wen !== 1'b0 || pend_mask !== 32'h0) begin
      failures++;
      $display("FAIL mdu_accept_cycle: ready=%b wen=%b pend=%h want 1 0 0", md_ready, rf_wen, pend_mask);
    end
    next_cycle();
    md_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pend_mask !== 32'h80) begin
      failures++;
      $display("FAIL mdu_pend_set: got %h want 00000080", pend_mask);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL mdu_drain: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (rf_wen !== 1'b1 || rf_waddr !== e.a || rf_wdata !== e.d) begin
        failures++;
        $display("FAIL mdu_drain: got wen=%b a=%0d d=%h want wen=1 a=%0d d=%h",
                 rf_wen, rf_waddr, rf_wdata, e.a, e.d);
      end
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (pend_mask !== 32'h0 || rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL mdu_after_drain: pend=%h wen=%b want 0 0", pend_mask, rf_wen);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    wr_t e;
    logic exp_hold;
    int wd = 0;
    for (int c = 0; c < 8; c++) begin
      wb_wen   = 1'b1;
      wb_waddr = 5'd10;
      wb_wdata = 64'h1000 + 64'(wd);
      md_valid = (c == 0);
      md_waddr = 5'd12;
      md_wdata = 64'h5555;
      exp_hold = (c == 5);
      if (exp_hold) sb.push_back('{a: 5'd12, d: 64'h5555});
      else          sb.push_back('{a: 5'd10, d: 64'h1000 + 64'(wd)});
      @(negedge clk);
      checks++;
      if (wb_hold !== exp_hold) begin
        failures++;
        $display("FAIL starve_hold c=%0d: got %b want %b", c, wb_hold, exp_hold);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL starve_write c=%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if (rf_wen !== 1'b1 || rf_waddr !== e.a || rf_wdata !== e.d) begin
          failures++;
          $display("FAIL starve_write c=%0d: got wen=%b a=%0d d=%h want wen=1 a=%0d d=%h",
                   c, rf_wen, rf_waddr, rf_wdata, e.a, e.d);
        end
      end
      next_cycle();
      if (!exp_hold) wd++;
    end
    wb_wen   = 1'b0;
    md_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    wr_t e;
    wr_t items [3];
    logic exp_hold, exp_ready;
    logic [31:0] exp_pend;
    int n_acc = 0;
    int n_drn = 0;
    int wd = 0;
    items[0] = '{a: 5'd1, d: 64'hA1};
    items[1] = '{a: 5'd2, d: 64'hB2};
    items[2] = '{a: 5'd3, d: 64'hC3};
    for (int c = 0; c < 17; c++) begin
      wb_wen   = 1'b1;
      wb_waddr = 5'd9;
      wb_wdata = 64'h9000 + 64'(wd);
      md_valid = (n_acc < 3);
      md_waddr = items[n_acc % 3].a;
      md_wdata = items[n_acc % 3].d;
      exp_hold  = (c == 5) || (c == 10) || (c == 15);
      exp_ready = !(c >= 2 && c <= 5);
      if (c == 0)       exp_pend = 32'h0;
      else if (c == 1)  exp_pend = 32'h2;
      else if (c <= 5)  exp_pend = 32'h6;
      else if (c == 6)  exp_pend = 32'h4;
      else if (c <= 10) exp_pend = 32'hC;
      else if (c <= 15) exp_pend = 32'h8;
      else              exp_pend = 32'h0;
      if (exp_hold) begin
        sb.push_back(items[n_drn]);
        n_drn++;
      end else begin
        sb.push_back('{a: 5'd9, d: 64'h9000 + 64'(wd)});
      end
      @(negedge clk);
      if (md_valid) begin
        checks++;
        if (md_ready !== exp_ready) begin
          failures++;
          $display("FAIL full_ready c=%0d: got %b want %b", c, md_ready, exp_ready);
        end
      end
      checks++;
      if (wb_hold !== exp_hold || pend_mask !== exp_pend) begin
        failures++;
        $display("FAIL full_state c=%0d: hold=%b pend=%h want hold=%b pend=%h",
                 c, wb_hold, pend_mask, exp_hold, exp_pend);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL full_write c=%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if (rf_wen !== 1'b1 || rf_waddr !== e.a || rf_wdata !== e.d) begin
          failures++;
          $display("FAIL full_write c=%0d: got wen=%b a=%0d d=%h want wen=1 a=%0d d=%h",
                   c, rf_wen, rf_waddr, rf_wdata, e.a, e.d);
        end
      end
      next_cycle();
      if (md_valid && exp_ready) n_acc++;
      if (!exp_hold) wd++;
    end
    wb_wen   = 1'b0;
    md_valid = 1'b0;
  endtask

  task automatic test_x0_drop();
    md_valid = 1'b1;
    md_waddr = 5'd0;
    md_wdata = 64'hDEAD;
    @(negedge clk);
    checks++;
    if (md_ready !== 1'b1 || rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL x0_handshake: ready=%b wen=%b want 1 0", md_ready, rf_wen);
    end
    next_cycle();
    md_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (pend_mask !== 32'h0 || rf_wen !== 1'b0 || md_ready !== 1'b1 || wb_hold !== 1'b0) begin
        failures++;
        $display("FAIL x0_no_enqueue c=%0d: pend=%h wen=%b ready=%b hold=%b want 0 0 1 0",
                 c, pend_mask, rf_wen, md_ready, wb_hold);
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    wr_t e;
    for (int c = 0; c < 3; c++) begin
      wb_wen   = 1'b1;
      wb_waddr = 5'd11;
      wb_wdata = 64'h7700 + 64'(c);
      md_valid = (c < 2);
      md_waddr = 5'd20 + 5'(c);
      md_wdata = 64'h2020 + 64'(c);
      sb.push_back('{a: 5'd11, d: 64'h7700 + 64'(c)});
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL arst_wb_write c=%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if (rf_wen !== 1'b1 || rf_waddr !== e.a || rf_wdata !== e.d) begin
          failures++;
          $display("FAIL arst_wb_write c=%0d: got wen=%b a=%0d d=%h want wen=1 a=%0d d=%h",
                   c, rf_wen, rf_waddr, rf_wdata, e.a, e.d);
        end
      end
      if (c == 2) begin
        checks++;
        if (pend_mask !== 32'h0030_0000 || md_ready !== 1'b0) begin
          failures++;
          $display("FAIL arst_queued: pend=%h ready=%b want 00300000 0", pend_mask, md_ready);
        end
      end else begin
        next_cycle();
      end
    end
    #2;
    rst      = 1'b1;
    wb_wen   = 1'b0;
    md_valid = 1'b0;
    #1;
    checks++;
    if (pend_mask !== 32'h0 || md_ready !== 1'b1 || wb_hold !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate: pend=%h ready=%b hold=%b want 0 1 0", pend_mask, md_ready, wb_hold);
    end
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rf_wen !== 1'b0 || pend_mask !== 32'h0) begin
        failures++;
        $display("FAIL arst_no_stale c=%0d: wen=%b pend=%h want 0 0", c, rf_wen, pend_mask);
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    wb_wen   = 1'b0;
    wb_waddr = '0;
    wb_wdata = '0;
    md_valid = 1'b0;
    md_waddr = '0;
    md_wdata = '0;

    test_reset();
    test_wb_only();
    test_mdu_idle();
    test_starvation();
    test_back_to_back();
    test_x0_drop();
    test_async_reset();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22040759_rf_warb.md
# ysyx_22040759_rf_warb

Register-file write-port arbiter for the single-issue 64-bit RISC-V core. It shares the one register-file write port between the in-order write-back stage and the multi-cycle mul/div unit (MDU). MDU results are held in a small FIFO, so the MDU never waits on the pipeline. A starvation counter can stall write-back so that buffered MDU results always drain. The block sits between the WB-stage write bus, the MDU result port and the register file.

## Interface
Parameters:
- DEPTH, 2: MDU result FIFO entries; power of two, ≥2.
- STARVE_MAX, 4: consecutive non-drained cycles of a valid FIFO head before WB is held.
- XLEN, 64: data width.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- wb_wen  in  1  WB write request; already qualified by ws_valid.
- wb_waddr  in  5  WB destination register.
- wb_wdata  in  XLEN  WB write data.
- wb_hold  out  1  forces the WB stage ready_go low; WB must keep its write stable.
- md_valid  in  1  MDU result valid.
- md_ready  out  1  FIFO can accept an MDU result.
- md_waddr  in  5  MDU destination register.
- md_wdata  in  XLEN  MDU result.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- pend_mask  out  32  bit i set when any valid FIFO entry targets register xi; drives the decode scoreboard.

## Operation
- MDU accept: an MDU result is accepted when md_valid && md_ready, and md_ready = !full.
  - When md_waddr==0, the handshake completes but nothing is enqueued.
- FIFO: circular buffer with head and tail pointers plus an occupancy count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Grant priority, combinational each cycle:
  - If wb_wen && !wb_hold, WB is granted.
  - Else, if the FIFO is non-empty, the FIFO head is granted (drain) and the head is popped at the clock edge.
  - Else, nothing is granted and rf_wen=0.
- WB writes with wb_waddr==0 pass through unchanged; the register file ignores x0.
- Starvation counter (width clog2(STARVE_MAX)+1):
  - Cleared on every drain and whenever the FIFO is empty.
  - Otherwise incremented each cycle the head is valid and not drained, saturating at STARVE_MAX.
- wb_hold = non-empty && counter==STARVE_MAX. A held cycle always drains the head.
- pend_mask is derived from registered entry state only. It sets a bit the cycle after enqueue and clears it the cycle after pop.

## Timing
- Reset values: FIFO empty, pointers 0, counter 0, pend_mask=0, wb_hold=0, md_ready=1. The rf_* outputs follow wb_* combinationally.
- MDU latency: a result accepted at edge N is writable in cycle N+1 at the earliest. There is no same-cycle bypass.
- Full FIFO: md_ready=0, even if a pop happens that cycle. Accept resumes the cycle after the pop.
- Enqueue and pop in the same cycle (FIFO not full): both happen and occupancy is unchanged.
- No WB traffic: one drain per cycle, DEPTH entries drain in DEPTH cycles.
- Continuous WB writes:
  - The head is held back for STARVE_MAX cycles, then wb_hold is asserted for exactly 1 cycle.
  - The head drains, the counter clears, and WB writes on the following cycle.
- Reset asserted mid-operation: all FIFO entries are discarded immediately (asynchronously). Any MDU handshake in that cycle is lost.

## Structure
- Shared package/define file: XLEN, register-index width (5), and the DEPTH and STARVE_MAX defaults, placed next to the existing wreg_* select constants.
- One sub-module, ysyx_22040759_rf_wfifo: a generic DEPTH×(5+XLEN) FIFO with push/pop/full/empty and per-entry valid/address outputs for the pend_mask OR-tree.
- The arbiter top holds the grant mux, starvation counter and pend_mask logic.

## Test plan
- WB only: wb_wen=1, waddr=5, wdata=0x1234 with MDU idle. Expect rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in the same cycle, and wb_hold stays 0.
- MDU, idle WB: md result (waddr=7, data=0xABCD) accepted at edge 0.
  - Cycle 1: pend_mask[7]=1 and rf writes x7=0xABCD.
  - Cycle 2: pend_mask=0.
- Starvation: wb_wen held at 1 continuously, one MDU result enqueued. Expect 4 cycles of WB writes, then wb_hold=1 with the FIFO head written, then WB resumes with its held data.
- Full FIFO: with wb_wen=1 continuously, push 3 MDU results back-to-back. Expect md_ready=0 after 2 accepts, and the third result accepted the cycle after the first drain.
- x0 drop: md_valid with waddr=0. Expect md_ready=1, the handshake completes, no enqueue, pend_mask unchanged, and no write.
- Async reset: assert rst between clock edges while 2 entries are queued. Expect empty state, pend_mask=0 and md_ready=1 immediately, and no stale write after release.
